hovalaag_frame_sequencer: RTL and testbench



---
 rtl/hovalaag_pkg.sv | 32 +++
 rtl/hovalaag_frame_sequencer_if.sv | 25 ++
 rtl/hovalaag_phase_ring.sv | 38 +++
 rtl/hovalaag_frame_sequencer.sv | 117 +++++++++++
 tb/tb_hovalaag_frame_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hovalaag_pkg.sv
// Shared constants and types for the Hovalaag frame sequencer.
// Phase indices name the role of each clock within a 10-clock frame.
package hovalaag_pkg;

    localparam int unsigned PHASES   = 10;  // frame length, one-hot width
    localparam int unsigned CHUNK_W  = 6;   // data pins per phase
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned IO_W     = 12;
    localparam int unsigned PIN_W    = 8;   // output pin count
    localparam int unsigned PC_W     = 8;

    localparam int unsigned PH_OUT_LO     = 0;
    localparam int unsigned PH_OUT_HI     = 1;
    localparam int unsigned PH_PC         = 2;
    localparam int unsigned PH_INSTR_LAST = 5;
    localparam int unsigned PH_IN_LO      = 6;
    localparam int unsigned PH_IN_HI      = 7;
    localparam int unsigned PH_STEP       = 8;
    localparam int unsigned PH_LATCH      = 9;

    // Chunks 0..4 fill the low 30 instruction bits; only the low 2 bits of
    // the phase-5 chunk fit, its upper bits (shadow 35:32) are dropped.
    localparam int unsigned SHADOW_W = PH_INSTR_LAST * CHUNK_W;
    localparam int unsigned TOP_W    = INSTR_W - SHADOW_W;

    // Latched core result as presented on the output pins.
    typedef struct packed {
        logic            valid;
        logic [IO_W-1:0] value;
    } core_result_t;

endpackage

// File: rtl/hovalaag_frame_sequencer_if.sv
// Sequencer <-> core bus.
//   master (sequencer): drives instr, in_data, step; reads core_out,
//                       core_out_valid, core_pc.
//   slave  (core):      the reverse.
interface hovalaag_frame_sequencer_if;
    import hovalaag_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic [IO_W-1:0]    in_data;
    logic               step;
    logic [IO_W-1:0]    core_out;
    logic               core_out_valid;
    logic [PC_W-1:0]    core_pc;

    modport master (
        output instr, in_data, step,
        input  core_out, core_out_valid, core_pc
    );

    modport slave (
        input  instr, in_data, step,
        output core_out, core_out_valid, core_pc
    );

endinterface

// File: rtl/hovalaag_phase_ring.sv
// One-hot frame phase rotator.
//   i_clk, i_reset : clock, synchronous active-high reset (to phase 0)
//   i_load         : synchronous restart to phase 0
//   o_phase        : registered one-hot phase, bit 0 = phase 0
//   o_wrap_c       : high in the last phase (next edge wraps to phase 0)
module hovalaag_phase_ring
    import hovalaag_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    output logic [PHASES-1:0] o_phase,
    output logic              o_wrap_c
);

    logic [PHASES-1:0] r_phase;
    logic [PHASES-1:0] w_phase_next;

    // Rotate left by one; a load forces phase 0.
    always_comb begin
        w_phase_next = {r_phase[PHASES-2:0], r_phase[PHASES-1]};
        if (i_load) begin
            w_phase_next = PHASES'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= PHASES'(1);
        end else begin
            r_phase <= w_phase_next;
        end
    end

    assign o_phase  = r_phase;
    assign o_wrap_c = r_phase[PHASES-1];

endmodule

// File: rtl/hovalaag_frame_sequencer.sv
// Frame-level controller for the Hovalaag core: assembles instruction and
// input word from 6-bit pin chunks, issues one execute strobe per complete
// frame, latches the core result and multiplexes it onto the output pins.
//   i_clk, i_reset : clock, synchronous active-high full reset
//   i_addr_reset   : synchronous framing restart (keeps instr/in_data/result)
//   i_data_in      : chunk pins
//   o_phase        : one-hot current phase
//   o_io_out       : registered phase-multiplexed output pins
//   bus            : core-side bus (instr, in_data, step / core result, pc)
module hovalaag_frame_sequencer
    import hovalaag_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_addr_reset,
    input  logic [CHUNK_W-1:0]          i_data_in,
    output logic [PHASES-1:0]           o_phase,
    output logic [PIN_W-1:0]            o_io_out,
    hovalaag_frame_sequencer_if.master  bus
);

    logic [PHASES-1:0]   w_phase;
    logic                w_wrap;
    logic [PIN_W-1:0]    w_io_mux;

    logic [SHADOW_W-1:0] r_shadow;
    logic [INSTR_W-1:0]  r_instr;
    logic [IO_W-1:0]     r_in_data;
    logic                r_frame_ok;
    logic                r_step;
    logic                r_stepped;   // step fired in the current frame
    core_result_t        r_result;
    logic [PIN_W-1:0]    r_io_out;

    hovalaag_phase_ring u_ring (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (i_addr_reset),
        .o_phase  (w_phase),
        .o_wrap_c (w_wrap)
    );

    // Output pin selection by the current phase; registered below.
    always_comb begin
        w_io_mux = '0;
        if (w_phase[PH_OUT_LO]) begin
            w_io_mux = r_result.value[PIN_W-1:0];
        end
        if (w_phase[PH_OUT_HI]) begin
            w_io_mux = {r_result.valid, 3'b000, r_result.value[IO_W-1:PIN_W]};
        end
        if (w_phase[PH_PC]) begin
            w_io_mux = bus.core_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow   <= '0;
            r_instr    <= '0;
            r_in_data  <= '0;
            r_frame_ok <= 1'b0;
            r_step     <= 1'b0;
            r_stepped  <= 1'b0;
            r_result   <= '0;
            r_io_out   <= '0;
        end else begin
            r_io_out <= w_io_mux;
            if (i_addr_reset) begin
                // Restart framing; a partially assembled frame is discarded.
                r_shadow   <= '0;
                r_frame_ok <= 1'b0;
                r_step     <= 1'b0;
                r_stepped  <= 1'b0;
            end else begin
                for (int unsigned k = 0; k < PH_INSTR_LAST; k++) begin
                    if (w_phase[k]) begin
                        r_shadow[k*CHUNK_W +: CHUNK_W] <= i_data_in;
                    end
                end
                // Handoff includes the final chunk captured on this same edge.
                if (w_phase[PH_INSTR_LAST]) begin
                    r_instr <= {i_data_in[TOP_W-1:0], r_shadow};
                end
                if (w_phase[PH_IN_LO]) begin
                    r_in_data[CHUNK_W-1:0] <= i_data_in;
                end
                if (w_phase[PH_IN_HI]) begin
                    r_in_data[IO_W-1:CHUNK_W] <= i_data_in;
                end

                // Step covers the phase-8 cycle only after a full frame.
                r_step <= w_phase[PH_IN_HI] & r_frame_ok;

                if (r_step) begin
                    r_stepped <= 1'b1;
                end else if (w_wrap) begin
                    r_stepped <= 1'b0;
                end

                if (w_wrap) begin
                    r_frame_ok <= 1'b1;
                    if (r_stepped) begin
                        r_result <= '{valid: bus.core_out_valid, value: bus.core_out};
                    end
                end
            end
        end
    end

    assign o_phase     = w_phase;
    assign o_io_out    = r_io_out;
    assign bus.instr   = r_instr;
    assign bus.in_data = r_in_data;
    assign bus.step    = r_step;

endmodule

// File: tb/tb_hovalaag_frame_sequencer.sv
// Scoreboard bench for hovalaag_frame_sequencer: the driver updates a
// phase-index reference model and queues the expected post-edge outputs;
// the monitor pops and compares after every rising edge.
module tb_hovalaag_frame_sequencer;

    logic       clk;
    logic       reset;
    logic       addr_reset;
    logic [5:0] data_in;
    logic [9:0] phase;
    logic [7:0] io_out;

    hovalaag_frame_sequencer_if u_bus ();

    hovalaag_frame_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_addr_reset (addr_reset),
        .i_data_in    (data_in),
        .o_phase      (phase),
        .o_io_out     (io_out),
        .bus          (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  phase;
        logic        step;
        logic [31:0] instr;
        logic [11:0] in_data;
        logic [7:0]  io;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: phase as an integer 0..9.
    int          m_ph;
    bit          m_fok;
    bit          m_step;
    bit          m_fired;
    logic [31:0] m_instr;
    logic [11:0] m_in;
    logic [11:0] m_out;
    bit          m_flag;
    logic [7:0]  m_io;
    logic [5:0]  m_chunk [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] assemble();
        logic [35:0] acc;
        acc = '0;
        for (int k = 0; k < 6; k++) acc = acc | (36'(m_chunk[k]) << (6 * k));
        return acc[31:0];
    endfunction

    task automatic model(input bit rst, input bit arst, input logic [5:0] din,
                         input logic [11:0] cout, input bit cv, input logic [7:0] pc);
        if (rst) begin
            m_ph = 0; m_fok = 0; m_step = 0; m_fired = 0;
            m_instr = '0; m_in = '0; m_out = '0; m_flag = 0; m_io = '0;
            for (int k = 0; k < 6; k++) m_chunk[k] = '0;
        end else begin
            case (m_ph)
                0:       m_io = m_out[7:0];
                1:       m_io = {m_flag, 3'b000, m_out[11:8]};
                2:       m_io = pc;
                default: m_io = 8'h00;
            endcase
            if (arst) begin
                m_ph = 0; m_fok = 0; m_step = 0; m_fired = 0;
                for (int k = 0; k < 6; k++) m_chunk[k] = '0;
            end else begin
                if (m_ph < 6) m_chunk[m_ph] = din;
                if (m_ph == 5) m_instr = assemble();
                if (m_ph == 6) m_in[5:0] = din;
                if (m_ph == 7) m_in[11:6] = din;
                if (m_ph == 9 && m_fired) begin
                    m_out  = cout;
                    m_flag = cv;
                end
                m_step = (m_ph == 7) && m_fok;
                if (m_step) m_fired = 1;
                if (m_ph == 9) begin
                    m_fok   = 1;
                    m_fired = 0;
                end
                m_ph = (m_ph + 1) % 10;
            end
        end
    endtask

    // One clock of stimulus; expectation is for the state after the next edge.
    task automatic cyc(input bit rst, input bit arst, input logic [5:0] din,
                       input logic [11:0] cout, input bit cv);
        exp_t       e;
        logic [7:0] pc;
        @(negedge clk);
        pc                   = 8'($urandom);
        reset                = rst;
        addr_reset           = arst;
        data_in              = din;
        u_bus.core_out       = cout;
        u_bus.core_out_valid = cv;
        u_bus.core_pc        = pc;
        model(rst, arst, din, cout, cv, pc);
        e.phase   = 10'(1) << m_ph;
        e.step    = m_step;
        e.instr   = m_instr;
        e.in_data = m_in;
        e.io      = m_io;
        exp_q.push_back(e);
    endtask

    task automatic cyc_rand(input bit rst, input bit arst);
        cyc(rst, arst, 6'($urandom), 12'($urandom), 1'($urandom));
    endtask

    task automatic align(input int ph);
        for (int i = 0; i < 10 && m_ph != ph; i++) cyc_rand(0, 0);
    endtask

    // Monitor: compare every cycle for which an expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase",   32'(phase),         32'(e.phase));
                chk("step",    32'(u_bus.step),    32'(e.step));
                chk("instr",   u_bus.instr,        e.instr);
                chk("in_data", 32'(u_bus.in_data), 32'(e.in_data));
                chk("io_out",  32'(io_out),        32'(e.io));
            end
        end
    end

    initial begin
        logic [5:0] dchunks [8];
        dchunks = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h3F, 6'h2A, 6'h15};

        reset = 1'b1; addr_reset = 1'b0; data_in = '0;
        u_bus.core_out = '0; u_bus.core_out_valid = 1'b0; u_bus.core_pc = '0;

        // Reset, then free run for three frames.
        cyc_rand(1, 0);
        cyc_rand(1, 0);
        repeat (30) cyc_rand(0, 0);

        // Directed chunk frame followed by a known core result.
        align(0);
        for (int i = 0; i < 8; i++) cyc(0, 0, dchunks[i], 12'($urandom), 1'($urandom));
        @(posedge clk);
        #2;
        chk("instr_directed",   u_bus.instr,        32'hC510_3081);
        chk("in_data_directed", 32'(u_bus.in_data), 32'h0000_056A);
        cyc(0, 0, 6'($urandom), 12'hABC, 1'b1);
        cyc(0, 0, 6'($urandom), 12'hABC, 1'b1);
        repeat (12) cyc_rand(0, 0);

        // addr_reset while step is high.
        align(8);
        cyc_rand(0, 1);
        repeat (25) cyc_rand(0, 0);

        // reset and addr_reset together mid-frame.
        align(4);
        cyc_rand(1, 1);
        repeat (24) cyc_rand(0, 0);

        // addr_reset in phase 3 with new chunks.
        align(3);
        cyc_rand(0, 1);
        repeat (25) cyc_rand(0, 0);

        // Randomised run with occasional restarts.
        repeat (400) cyc_rand($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
